uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 23 ++
 rtl/uart_byte_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_pkg
// Brief    : Shared FSM state encodings and UART frame constants.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_fifo_pkg;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SEND  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = c_ST_IDLE,
    SEND  = c_ST_SEND,
    DRAIN = c_ST_DRAIN
  } txState_t;

  localparam int c_DATA_BITS = 8;
  localparam int c_STOP_BITS = 1;

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_fifo
// Brief    : Byte FIFO with count-derived full/empty and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [c_DATA_BITS-1:0] wrData,
  input  logic                   pop,
  output logic [c_DATA_BITS-1:0] rdData,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic                   overflow
);

  logic [c_DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wrPtr;
  logic [AW-1:0]          r_rdPtr;
  logic [AW:0]            r_count;
  logic                   r_overflow;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_doPush;
  logic                   w_doPop;

  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  // A push is judged against the pre-pop fill level, so a full FIFO drops it
  // even when a pop frees a slot in the same cycle.
  assign w_doPush = push & ~w_full;
  assign w_doPop  = pop & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + (AW+1)'(w_doPush) - (AW+1)'(w_doPop);
      if (push && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= wrData;
  end

  assign rdData   = r_mem[r_rdPtr];
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO feeding a UART transmitter through a StartTx/readyTx
//            level handshake, with one tx_done pulse per byte sent.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [c_DATA_BITS-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic                   overflow,
  output logic                   StartTx,
  output logic [c_DATA_BITS-1:0] BufferTx,
  input  logic                   readyTx,
  output logic                   tx_done
);

  txState_t               r_state;
  txState_t               w_stateNext;
  logic                   r_startTx;
  logic                   w_startTxNext;
  logic [c_DATA_BITS-1:0] r_bufferTx;
  logic [c_DATA_BITS-1:0] w_bufferTxNext;
  logic                   r_txDone;
  logic                   w_txDoneNext;
  logic                   w_pop;
  logic [c_DATA_BITS-1:0] w_rdData;
  logic                   w_empty;

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en),
    .wrData   (wr_data),
    .pop      (w_pop),
    .rdData   (w_rdData),
    .full     (full),
    .empty    (w_empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_startTx  <= 1'b0;
      r_bufferTx <= '0;
      r_txDone   <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_startTx  <= w_startTxNext;
      r_bufferTx <= w_bufferTxNext;
      r_txDone   <= w_txDoneNext;
    end
  end

  // SEND waits for the stop bit to start, DRAIN for it to finish; the two
  // levels of readyTx stand in for an edge detector.
  always_comb begin
    w_stateNext    = r_state;
    w_startTxNext  = r_startTx;
    w_bufferTxNext = r_bufferTx;
    w_txDoneNext   = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        w_startTxNext = 1'b0;
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_bufferTxNext = w_rdData;
          w_startTxNext  = 1'b1;
          w_stateNext    = SEND;
        end
      end
      SEND: begin
        w_startTxNext = 1'b1;
        if (readyTx) begin
          w_startTxNext = 1'b0;
          w_stateNext   = DRAIN;
        end
      end
      DRAIN: begin
        w_startTxNext = 1'b0;
        if (!readyTx) begin
          w_txDoneNext = 1'b1;
          w_stateNext  = IDLE;
        end
      end
      default: begin
        w_startTxNext = 1'b0;
        w_stateNext   = IDLE;
      end
    endcase
  end

  assign empty    = w_empty;
  assign StartTx  = r_startTx;
  assign BufferTx = r_bufferTx;
  assign tx_done  = r_txDone;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed self-checking bench for uart_tx_fifo (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       readyTx = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       StartTx;
  logic [7:0] BufferTx;
  logic       tx_done;

  int checks    = 0;
  int failures  = 0;
  int doneCount = 0;

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .StartTx  (StartTx),
    .BufferTx (BufferTx),
    .readyTx  (readyTx),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (tx_done === 1'b1) doneCount++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    wr_en = 1'b0;
    readyTx = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  // Transmitter model: wait for StartTx, hold d1 cycles, raise readyTx for
  // d2+1 cycles, then wait for tx_done. Returns the byte and a timeout flag.
  task automatic serve(input int d1, input int d2, output logic [7:0] b, output bit ok);
    int n;
    ok = 1'b0;
    b = 8'h00;
    n = 0;
    while (StartTx !== 1'b1 && n < 60) begin tick(); n++; end
    if (StartTx === 1'b1) begin
      b = BufferTx;
      repeat (d1) tick();
      readyTx = 1'b1;
      tick();
      repeat (d2) tick();
      readyTx = 1'b0;
      n = 0;
      do begin tick(); n++; end while (tx_done !== 1'b1 && n < 10);
      ok = (tx_done === 1'b1);
    end
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (StartTx !== 1'b0)    begin failures++; $display("FAIL reset_StartTx got=%b exp=0", StartTx); end
    checks++; if (BufferTx !== 8'h00)  begin failures++; $display("FAIL reset_BufferTx got=%h exp=00", BufferTx); end
    checks++; if (tx_done !== 1'b0)    begin failures++; $display("FAIL reset_tx_done got=%b exp=0", tx_done); end
    checks++; if (empty !== 1'b1)      begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0)       begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 5'd0)      begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_single();
    int d0;
    int bad;
    d0 = doneCount;
    bad = 0;
    pushByte(8'hA5);
    checks++; if (StartTx !== 1'b0) begin failures++; $display("FAIL single_start_early got=%b exp=0", StartTx); end
    tick();
    checks++; if (StartTx !== 1'b1) begin failures++; $display("FAIL single_start_latency got=%b exp=1", StartTx); end
    checks++; if (BufferTx !== 8'hA5) begin failures++; $display("FAIL single_buffer got=%h exp=a5", BufferTx); end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (StartTx !== 1'b1 || BufferTx !== 8'hA5) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL single_send_hold got=%0d_bad_cycles exp=0", bad); end
    readyTx = 1'b1;
    tick();
    checks++; if (StartTx !== 1'b0) begin failures++; $display("FAIL single_start_drop got=%b exp=0", StartTx); end
    bad = 0;
    for (int i = 0; i < 79; i++) begin
      tick();
      if (tx_done !== 1'b0 || StartTx !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL single_drain_hold got=%0d_bad_cycles exp=0", bad); end
    readyTx = 1'b0;
    tick();
    checks++; if (tx_done !== 1'b1) begin failures++; $display("FAIL single_tx_done got=%b exp=1", tx_done); end
    tick();
    checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL single_tx_done_pulse got=%b exp=0", tx_done); end
    checks++; if (doneCount - d0 != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", doneCount - d0); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    logic [7:0] b;
    bit ok;
    int d0;
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    d0 = doneCount;
    for (int i = 0; i < 3; i++) pushByte(exp[i]);
    for (int i = 0; i < 3; i++) begin
      serve(3, 4, b, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout frame=%0d got=timeout exp=tx_done", i); end
      checks++; if (b !== exp[i]) begin failures++; $display("FAIL b2b_byte frame=%0d got=%h exp=%h", i, b, exp[i]); end
    end
    tick();
    checks++; if (doneCount - d0 != 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", doneCount - d0); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_full_overflow();
    logic [7:0] b;
    bit ok;
    doReset();
    for (int i = 0; i < 16; i++) pushByte(8'h40 + 8'(i));
    checks++; if (count !== 5'd15) begin failures++; $display("FAIL ovf_count16 got=%0d exp=15", count); end
    checks++; if (full !== 1'b0)   begin failures++; $display("FAIL ovf_full16 got=%b exp=0", full); end
    pushByte(8'h50);
    checks++; if (full !== 1'b1)     begin failures++; $display("FAIL ovf_full17 got=%b exp=1", full); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_flag17 got=%b exp=0", overflow); end
    pushByte(8'hDD);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag18 got=%b exp=1", overflow); end
    checks++; if (count !== 5'd16)   begin failures++; $display("FAIL ovf_count18 got=%0d exp=16", count); end
    // Finish the in-flight byte and land a push on the cycle the FSM pops.
    readyTx = 1'b1;
    tick();
    readyTx = 1'b0;
    tick();
    checks++; if (tx_done !== 1'b1) begin failures++; $display("FAIL ovf_done got=%b exp=1", tx_done); end
    pushByte(8'hEE);
    checks++; if (count !== 5'd15)   begin failures++; $display("FAIL pushpop_count got=%0d exp=15", count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL pushpop_overflow got=%b exp=1", overflow); end
    checks++; if (BufferTx !== 8'h41) begin failures++; $display("FAIL pushpop_buffer got=%h exp=41", BufferTx); end
    for (int i = 0; i < 16; i++) begin
      serve(1, 1, b, ok);
      checks++; if (!ok || b !== 8'h41 + 8'(i)) begin failures++; $display("FAIL ovf_drain idx=%0d got=%h ok=%0d exp=%h", i, b, ok, 8'h41 + 8'(i)); end
    end
    repeat (3) tick();
    checks++; if (empty !== 1'b1 || StartTx !== 1'b0) begin failures++; $display("FAIL ovf_final got=empty%b_start%b exp=empty1_start0", empty, StartTx); end
  endtask

  task automatic test_reset_midframe();
    int d0;
    int bad;
    doReset();
    for (int i = 0; i < 6; i++) pushByte(8'h70 + 8'(i));
    checks++; if (count !== 5'd5 || StartTx !== 1'b1) begin failures++; $display("FAIL mid_setup got=count%0d_start%b exp=count5_start1", count, StartTx); end
    d0 = doneCount;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (StartTx !== 1'b0) begin failures++; $display("FAIL mid_start got=%b exp=0", StartTx); end
    checks++; if (count !== 5'd0)   begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1)   begin failures++; $display("FAIL mid_empty got=%b exp=1", empty); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      readyTx = (i == 1);
      tick();
      if (StartTx !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    readyTx = 1'b0;
    checks++; if (bad != 0 || doneCount != d0) begin failures++; $display("FAIL mid_quiet got=%0d_bad_%0d_done exp=0_0", bad, doneCount - d0); end
  endtask

  task automatic test_wrap();
    logic [7:0] b;
    logic [7:0] e;
    bit ok;
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 5; i++) pushByte(8'h80 + 8'(blk * 5 + i));
      for (int i = 0; i < 5; i++) begin
        e = 8'h80 + 8'(blk * 5 + i);
        serve(2, 2, b, ok);
        checks++; if (!ok || b !== e) begin failures++; $display("FAIL wrap_byte idx=%0d got=%h ok=%0d exp=%h", blk * 5 + i, b, ok, e); end
      end
    end
    tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_overflow();
    test_reset_midframe();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
